// File: rtl/cond_exec_ctrl.sv
// Execute-stage control for the IITB-RISC arithmetic/logic group: conditional decode
// against forwarded carry/zero flags, plus the in-flight flag pipe and architectural C/Z.
module cond_exec_ctrl #(
  parameter int FLAG_PIPE = 2,
  parameter int ALUOP_W   = 2,
  parameter int OPC_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        instr,
  input  logic [ALUOP_W-1:0] alu_op_default,
  input  logic               reg_we_in,
  input  logic               alu_carry,
  input  logic               alu_zero,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_we_out,
  output logic               carry_we,
  output logic               zero_we,
  output logic               squashed,
  output logic               arch_carry,
  output logic               arch_zero
);

  localparam int TAIL = FLAG_PIPE - 1;

  localparam logic [OPC_W-1:0]   OPC_ADI   = OPC_W'(0);
  localparam logic [OPC_W-1:0]   OPC_ADD   = OPC_W'(1);
  localparam logic [OPC_W-1:0]   OPC_NDU   = OPC_W'(2);
  localparam logic [ALUOP_W-1:0] OP_ADD    = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] OP_NAND   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] OP_SQUASH = ALUOP_W'(2);

  // EX-stage registers
  logic               ex_valid_r;
  logic [ALUOP_W-1:0] ex_op_r;
  logic               ex_rwe_r;
  logic               ex_cwe_r;
  logic               ex_zwe_r;
  logic               ex_sq_r;

  // In-flight flag pipe, stage 0 is youngest, TAIL commits
  logic [FLAG_PIPE-1:0] pv_r;
  logic [FLAG_PIPE-1:0] pcwe_r;
  logic [FLAG_PIPE-1:0] pzwe_r;
  logic [FLAG_PIPE-1:0] pc_r;
  logic [FLAG_PIPE-1:0] pz_r;
  logic                 arch_c_r;
  logic                 arch_z_r;

  // Decode and forwarding
  logic [OPC_W-1:0]   opc_s;
  logic [1:0]         cond_s;
  logic               fwd_c_s;
  logic               fwd_z_s;
  logic               alu_grp_s;
  logic               arith_s;
  logic               cond_ok_s;
  logic [ALUOP_W-1:0] dec_op_s;
  logic               dec_rwe_s;
  logic               dec_cwe_s;
  logic               dec_zwe_s;
  logic               dec_sq_s;
  logic               accept_s;
  logic               advance_s;
  logic               unused_instr_s;

  assign opc_s          = instr[15:16-OPC_W];
  assign cond_s         = instr[1:0];
  assign unused_instr_s = ^instr[15-OPC_W:2];

  assign in_ready  = !stall && !flush;
  assign accept_s  = in_valid && in_ready;
  assign advance_s = flush || !stall;

  // Youngest writer wins: EX, then stage 0 .. TAIL, then architectural flag
  always_comb begin
    fwd_c_s = arch_c_r;
    fwd_z_s = arch_z_r;
    for (int i = FLAG_PIPE - 1; i >= 0; i--) begin
      fwd_c_s = (pv_r[i] && pcwe_r[i]) ? pc_r[i] : fwd_c_s;
      fwd_z_s = (pv_r[i] && pzwe_r[i]) ? pz_r[i] : fwd_z_s;
    end
    fwd_c_s = (ex_valid_r && ex_cwe_r) ? alu_carry : fwd_c_s;
    fwd_z_s = (ex_valid_r && ex_zwe_r) ? alu_zero  : fwd_z_s;
  end

  // Classify the {opcode, cond} key and evaluate its condition
  always_comb begin
    alu_grp_s = 1'b0;
    arith_s   = 1'b0;
    cond_ok_s = 1'b1;
    if (opc_s == OPC_ADI) begin
      alu_grp_s = 1'b1;
      arith_s   = 1'b1;
    end else if (opc_s == OPC_ADD) begin
      alu_grp_s = 1'b1;
      arith_s   = 1'b1;
      case (cond_s)
        2'b10:   cond_ok_s = fwd_c_s;
        2'b01:   cond_ok_s = fwd_z_s;
        default: cond_ok_s = 1'b1;
      endcase
    end else if (opc_s == OPC_NDU) begin
      case (cond_s)
        2'b00: begin
          alu_grp_s = 1'b1;
          cond_ok_s = 1'b1;
        end
        2'b10: begin
          alu_grp_s = 1'b1;
          cond_ok_s = fwd_c_s;
        end
        2'b01: begin
          alu_grp_s = 1'b1;
          cond_ok_s = fwd_z_s;
        end
        default: begin
          alu_grp_s = 1'b0;
          cond_ok_s = 1'b1;
        end
      endcase
    end else begin
      alu_grp_s = 1'b0;
    end
  end

  // Produce ALU op and write enables from the classified key
  always_comb begin
    dec_op_s  = alu_op_default;
    dec_rwe_s = reg_we_in;
    dec_cwe_s = 1'b0;
    dec_zwe_s = 1'b0;
    dec_sq_s  = 1'b0;
    if (!alu_grp_s) begin
      dec_op_s  = alu_op_default;
      dec_rwe_s = reg_we_in;
    end else if (!reg_we_in) begin
      dec_op_s  = alu_op_default;
      dec_rwe_s = 1'b0;
    end else if (!cond_ok_s) begin
      dec_op_s  = OP_SQUASH;
      dec_rwe_s = 1'b0;
      dec_sq_s  = 1'b1;
    end else begin
      dec_op_s  = arith_s ? OP_ADD : OP_NAND;
      dec_rwe_s = 1'b1;
      dec_cwe_s = arith_s;
      dec_zwe_s = 1'b1;
    end
  end

  // EX register: load on accept, bubble on idle or flush, hold on stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= '0;
      ex_rwe_r   <= 1'b0;
      ex_cwe_r   <= 1'b0;
      ex_zwe_r   <= 1'b0;
      ex_sq_r    <= 1'b0;
    end else if (accept_s) begin
      ex_valid_r <= 1'b1;
      ex_op_r    <= dec_op_s;
      ex_rwe_r   <= dec_rwe_s;
      ex_cwe_r   <= dec_cwe_s;
      ex_zwe_r   <= dec_zwe_s;
      ex_sq_r    <= dec_sq_s;
    end else if (advance_s) begin
      ex_valid_r <= 1'b0;
      ex_op_r    <= '0;
      ex_rwe_r   <= 1'b0;
      ex_cwe_r   <= 1'b0;
      ex_zwe_r   <= 1'b0;
      ex_sq_r    <= 1'b0;
    end else begin
      ex_valid_r <= ex_valid_r;
    end
  end

  // Flag pipe shift and tail commit; a flush still lets the tail commit but kills the rest
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pv_r     <= '0;
      pcwe_r   <= '0;
      pzwe_r   <= '0;
      pc_r     <= '0;
      pz_r     <= '0;
      arch_c_r <= 1'b0;
      arch_z_r <= 1'b0;
    end else if (advance_s) begin
      if (pv_r[TAIL] && pcwe_r[TAIL]) begin
        arch_c_r <= pc_r[TAIL];
      end
      if (pv_r[TAIL] && pzwe_r[TAIL]) begin
        arch_z_r <= pz_r[TAIL];
      end
      pv_r[0]   <= ex_valid_r && !flush;
      pcwe_r[0] <= ex_cwe_r;
      pzwe_r[0] <= ex_zwe_r;
      pc_r[0]   <= alu_carry;
      pz_r[0]   <= alu_zero;
      for (int i = 1; i < FLAG_PIPE; i++) begin
        pv_r[i]   <= pv_r[i-1] && !flush;
        pcwe_r[i] <= pcwe_r[i-1];
        pzwe_r[i] <= pzwe_r[i-1];
        pc_r[i]   <= pc_r[i-1];
        pz_r[i]   <= pz_r[i-1];
      end
    end else begin
      arch_c_r <= arch_c_r;
    end
  end

  assign out_valid  = ex_valid_r;
  assign alu_op     = ex_op_r;
  assign reg_we_out = ex_rwe_r;
  assign carry_we   = ex_cwe_r;
  assign zero_we    = ex_zwe_r;
  assign squashed   = ex_sq_r;
  assign arch_carry = arch_c_r;
  assign arch_zero  = arch_z_r;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Directed bench for cond_exec_ctrl: table of single-cycle decode vectors plus
// hand-written sequences for commit latency, flush, stall and async reset.
module tb_cond_exec_ctrl;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [1:0]  alu_op_default;
  logic        reg_we_in;
  logic        alu_carry;
  logic        alu_zero;
  logic        stall;
  logic        flush;
  logic        out_valid;
  logic [1:0]  alu_op;
  logic        reg_we_out;
  logic        carry_we;
  logic        zero_we;
  logic        squashed;
  logic        arch_carry;
  logic        arch_zero;

  int errs;
  int checks;

  cond_exec_ctrl #(.FLAG_PIPE(2), .ALUOP_W(2), .OPC_W(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .instr          (instr),
    .alu_op_default (alu_op_default),
    .reg_we_in      (reg_we_in),
    .alu_carry      (alu_carry),
    .alu_zero       (alu_zero),
    .stall          (stall),
    .flush          (flush),
    .out_valid      (out_valid),
    .alu_op         (alu_op),
    .reg_we_out     (reg_we_out),
    .carry_we       (carry_we),
    .zero_we        (zero_we),
    .squashed       (squashed),
    .arch_carry     (arch_carry),
    .arch_zero      (arch_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {out_valid, alu_op, reg_we_out, carry_we, zero_we, squashed}
  function automatic logic [6:0] outs();
    return {out_valid, alu_op, reg_we_out, carry_we, zero_we, squashed};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    in_valid       = 1'b0;
    instr          = 16'h0000;
    alu_op_default = 2'b00;
    reg_we_in      = 1'b1;
    alu_carry      = 1'b0;
    alu_zero       = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        vld;
    logic [15:0] ins;
    logic        rwe;
    logic [1:0]  dflt;
    logic        c;
    logic        z;
    logic [6:0]  exp;
  } vec_t;

  vec_t vt[15];

  initial begin
    errs   = 0;
    checks = 0;

    // vld, instr, reg_we_in, default op, ALU C/Z while in EX, expected outputs
    vt[0]  = '{1'b1, 16'h1000, 1'b1, 2'b11, 1'b1, 1'b0, 7'b1001110}; // ADD
    vt[1]  = '{1'b1, 16'h1002, 1'b1, 2'b11, 1'b0, 1'b1, 7'b1001110}; // ADC, C=1 from EX
    vt[2]  = '{1'b1, 16'h1002, 1'b1, 2'b11, 1'b0, 1'b0, 7'b1100001}; // ADC, C=0 from EX
    vt[3]  = '{1'b1, 16'h1001, 1'b1, 2'b11, 1'b1, 1'b0, 7'b1001110}; // ADZ, Z=1 from stage0
    vt[4]  = '{1'b1, 16'h2001, 1'b1, 2'b11, 1'b0, 1'b0, 7'b1100001}; // NDZ, Z=0 from EX
    vt[5]  = '{1'b1, 16'h2002, 1'b1, 2'b11, 1'b0, 1'b1, 7'b1011010}; // NDC, C=1 from stage0
    vt[6]  = '{1'b1, 16'h2000, 1'b1, 2'b11, 1'b0, 1'b0, 7'b1011010}; // NDU
    vt[7]  = '{1'b1, 16'h0123, 1'b1, 2'b11, 1'b0, 1'b0, 7'b1001110}; // ADI
    vt[8]  = '{1'b1, 16'h1003, 1'b1, 2'b11, 1'b0, 1'b0, 7'b1001110}; // ADL
    vt[9]  = '{1'b1, 16'h4000, 1'b1, 2'b11, 1'b0, 1'b0, 7'b1111000}; // non-ALU
    vt[10] = '{1'b1, 16'h2003, 1'b0, 2'b01, 1'b0, 1'b0, 7'b1010000}; // NDx cond 11 is non-ALU
    vt[11] = '{1'b1, 16'h1000, 1'b0, 2'b11, 1'b0, 1'b0, 7'b1110000}; // ADD without reg write
    vt[12] = '{1'b1, 16'h1002, 1'b0, 2'b11, 1'b0, 1'b0, 7'b1110000}; // ADC without reg write
    vt[13] = '{1'b1, 16'h3000, 1'b1, 2'b00, 1'b0, 1'b0, 7'b1001000}; // non-ALU, op 00
    vt[14] = '{1'b0, 16'h1000, 1'b1, 2'b11, 1'b0, 1'b0, 7'b0000000}; // bubble

    // Reset state
    do_reset();
    check("reset_outs", 16'(outs()), 16'h0000);
    check("reset_arch", {14'd0, arch_carry, arch_zero}, 16'h0000);
    check("reset_ready", {15'd0, in_ready}, 16'h0001);
    stall = 1'b1;
    #1;
    check("ready_stall", {15'd0, in_ready}, 16'h0000);
    stall = 1'b0;
    #1;

    // Decode table
    for (int i = 0; i < 15; i++) begin
      in_valid       = vt[i].vld;
      instr          = vt[i].ins;
      reg_we_in      = vt[i].rwe;
      alu_op_default = vt[i].dflt;
      step();
      check($sformatf("vec%0d", i), 16'(outs()), 16'(vt[i].exp));
      alu_carry = vt[i].c;
      alu_zero  = vt[i].z;
    end

    // Commit latency: arch_carry set exactly 3 edges after accept
    do_reset();
    in_valid = 1'b1;
    instr    = 16'h1000;
    step();
    check("add_outs", 16'(outs()), 16'h004E);
    alu_carry = 1'b1;
    alu_zero  = 1'b0;
    in_valid  = 1'b0;
    step();
    check("commit_e1", {15'd0, arch_carry}, 16'h0000);
    alu_carry = 1'b0;
    step();
    check("commit_e2", {15'd0, arch_carry}, 16'h0000);
    step();
    check("commit_e3", {14'd0, arch_carry, arch_zero}, 16'h0002);

    // NDZ sees Z from pipe stage 1 while arch_zero is still 0
    do_reset();
    in_valid = 1'b1;
    instr    = 16'h2000;
    step();
    alu_zero = 1'b1;
    in_valid = 1'b0;
    step();
    alu_zero = 1'b0;
    step();
    in_valid = 1'b1;
    instr    = 16'h2001;
    #1;
    check("ndz_arch_z_pre", {15'd0, arch_zero}, 16'h0000);
    step();
    check("ndz_outs", 16'(outs()), 16'h005A);
    in_valid = 1'b0;

    // Flush: tail (C=1) commits, stage0 (C=0) discarded
    do_reset();
    in_valid = 1'b1;
    instr    = 16'h1000;
    step();
    alu_carry = 1'b1;
    step();
    alu_carry = 1'b0;
    in_valid  = 1'b0;
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    #1;
    check("flush_ready", {15'd0, in_ready}, 16'h0000);
    check("flush_arch_pre", {15'd0, arch_carry}, 16'h0000);
    step();
    check("flush_arch", {15'd0, arch_carry}, 16'h0001);
    check("flush_outv", {15'd0, out_valid}, 16'h0000);
    flush    = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    check("flush_discard", {14'd0, arch_carry, arch_zero}, 16'h0002);

    // Stall for 3 cycles with ADD in EX
    do_reset();
    in_valid = 1'b1;
    instr    = 16'h1000;
    step();
    alu_carry = 1'b1;
    alu_zero  = 1'b1;
    stall     = 1'b1;
    #1;
    check("stall_ready", {15'd0, in_ready}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_outs%0d", k), 16'(outs()), 16'h004E);
      check($sformatf("stall_arch%0d", k), {14'd0, arch_carry, arch_zero}, 16'h0000);
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    step();
    check("resume_bubble", {15'd0, out_valid}, 16'h0000);
    alu_carry = 1'b0;
    alu_zero  = 1'b0;
    step();
    check("resume_e2", {14'd0, arch_carry, arch_zero}, 16'h0000);
    step();
    check("resume_commit", {14'd0, arch_carry, arch_zero}, 16'h0003);

    // Non-ALU opcode then asynchronous reset mid-cycle
    in_valid       = 1'b1;
    instr          = 16'h4000;
    alu_op_default = 2'b11;
    reg_we_in      = 1'b1;
    step();
    check("nonalu_outs", 16'(outs()), 16'h0078);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_outs", 16'(outs()), 16'h0000);
    check("async_arch", {14'd0, arch_carry, arch_zero}, 16'h0000);
    check("async_ready", {15'd0, in_ready}, 16'h0001);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
